rtx_fb_writer: RTL and testbench
================================

RTX_FB_WRITER -- requirements
Module: rtx_fb_writer

Interface
REQ-001 SHALL have parameter WIDTH, default 1280, meaning horizontal resolution in pixels.
REQ-002 SHALL have parameter HEIGHT, default 720, meaning vertical resolution in pixels.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port frame_start, input, 1 bit: one-cycle pulse that arms a new frame.
REQ-006 SHALL have port accum_en, input, 1 bit: blend the incoming pixel with the stored pixel when high.
REQ-007 SHALL have port pixel_in, input, 16 bits: RGB565 sample from the tracer wrapper, with r in [4:0], g in [10:5], b in [15:11].
REQ-008 SHALL have port pixel_valid, input, 1 bit: the tracer's delayed ray_done; pixel_in is valid this cycle.
REQ-009 SHALL have port fb_rd_addr, output, $clog2(WIDTH*HEIGHT) bits: framebuffer read address.
REQ-010 SHALL have port fb_rd_data, input, 16 bits: framebuffer read data, one cycle after fb_rd_addr.
REQ-011 SHALL have port fb_wr_addr, output, $clog2(WIDTH*HEIGHT) bits: framebuffer write address.
REQ-012 SHALL have port fb_wr_data, output, 16 bits: framebuffer write data.
REQ-013 SHALL have port fb_wr_en, output, 1 bit: framebuffer write strobe.
REQ-014 SHALL have port pixel_h, output, 11 bits: column of the next expected pixel.
REQ-015 SHALL have port pixel_v, output, 10 bits: row of the next expected pixel.
REQ-016 SHALL have port frame_done, output, 1 bit: one-cycle pulse when the last write of a frame issues.
REQ-017 SHALL have port frame_count, output, 16 bits: number of completed frames.
REQ-018 SHALL have port drop_flag, output, 1 bit: sticky flag set when a pixel arrives while not armed.

Function
REQ-019 SHALL implement FSM states IDLE and ACTIVE.
REQ-020 SHALL move from IDLE to ACTIVE on frame_start, zeroing pixel_h, pixel_v and the linear address.
REQ-021 SHALL, in ACTIVE, accept each pixel_valid beat: present fb_rd_addr equal to the current address in the same cycle, then advance pixel_h; when pixel_h reaches WIDTH-1, wrap pixel_h to 0 and increment pixel_v.
REQ-022 SHALL keep the linear address as a running counter (address = pixel_v*WIDTH + pixel_h), with no multiplier.
REQ-023 SHALL issue the write exactly 2 cycles after the accepting pixel_valid (read in cycle N, data in N+1, registered write in N+2); full throughput, one pixel per cycle, no stall.
REQ-024 SHALL select write data as follows: if accum_en (sampled with the pixel) is high and frame_count is nonzero, each channel = (stored + new) >> 1, computed per 5/6/5-bit channel with a 1-bit-wider sum and truncation; otherwise write pixel_in unchanged.
REQ-025 SHALL, on the beat at address WIDTH*HEIGHT-1, return to IDLE; frame_done SHALL pulse with that pixel's write, and frame_count SHALL increment (wrapping at 65535 to 0) in that same cycle.
REQ-026 SHALL, on pixel_valid in IDLE, drop the pixel with no write and set drop_flag; drop_flag clears only on reset.
REQ-027 SHALL, when frame_start and pixel_valid coincide, treat the pixel as address 0 of the new frame.
REQ-028 SHALL, on frame_start while ACTIVE, restart at address 0; in-flight writes complete, frame_count is unchanged and no frame_done pulse occurs.
REQ-029 SHALL allow back-to-back frames: a frame_start in the cycle after the last pixel is accepted with no gap.

Reset
REQ-030 SHALL, with rst_n low, force asynchronously: state IDLE; pixel_h, pixel_v, address, frame_count, fb_rd_addr and fb_wr_addr to 0; fb_wr_data to 0; fb_wr_en, frame_done and drop_flag to 0; all pipeline valid bits cleared.
REQ-031 SHALL ensure that writes in flight when reset asserts never issue.

Verification (WIDTH=4, HEIGHT=2)
REQ-032 SHALL cover: frame_start, then 8 consecutive beats of pixel_in=16'h1234 -> writes to addr 0..7, each 2 cycles after its beat; frame_done with the addr-7 write; frame_count=1.
REQ-033 SHALL cover: second frame with accum_en=1, stored 16'h0000, pixel_in 16'hFFFF -> fb_wr_data 16'h7BEF (r=15, g=31, b=15).
REQ-034 SHALL cover: pixel_valid with no frame_start after reset -> no fb_wr_en and drop_flag=1.
REQ-035 SHALL cover: frame_start after 5 beats, then 8 beats -> last write to addr 7, frame_count increments by 1 only, pixel_h/pixel_v=0/0 after.
REQ-036 SHALL cover: frame_start coincident with the first pixel_valid, followed by gapped beats -> first write to addr 0; pixel_h/pixel_v step (1,0),(2,0),(3,0),(0,1).
REQ-037 SHALL cover: rst_n low one cycle after a beat -> no write issues; all outputs 0 asynchronously.

Source files
------------

// File: rtl/rtx_fb_writer.sv
// rtx_fb_writer: streams traced RGB565 pixels into a framebuffer in raster order,
// optionally averaging each new sample with the pixel already stored there.
module rtx_fb_writer #(
  parameter int WIDTH  = 1280,
  parameter int HEIGHT = 720,
  localparam int AW = $clog2(WIDTH*HEIGHT)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic          accum_en,
  input  logic [15:0]   pixel_in,
  input  logic          pixel_valid,
  output logic [AW-1:0] fb_rd_addr,
  input  logic [15:0]   fb_rd_data,
  output logic [AW-1:0] fb_wr_addr,
  output logic [15:0]   fb_wr_data,
  output logic          fb_wr_en,
  output logic [10:0]   pixel_h,
  output logic [9:0]    pixel_v,
  output logic          frame_done,
  output logic [15:0]   frame_count,
  output logic          drop_flag
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nxt;
  logic [AW-1:0] addr, cur_a, a1;
  logic [10:0] cur_h;
  logic [9:0] cur_v;
  logic accept, last, hwrap, v1, ac1, l1;
  logic [15:0] p1, blend;
  logic [5:0] sr, sb;
  logic [6:0] sg;
  // A frame_start in the same cycle as a beat makes that beat pixel 0.
  assign cur_h = frame_start ? '0 : pixel_h;
  assign cur_v = frame_start ? '0 : pixel_v;
  assign cur_a = frame_start ? '0 : addr;
  assign hwrap = cur_h == 11'(WIDTH-1);
  assign fb_rd_addr = cur_a;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = last ? IDLE : frame_start ? ACTIVE : state;
  always_comb begin
    accept = pixel_valid & (frame_start | state == ACTIVE);
    last = accept & (cur_a == AW'(WIDTH*HEIGHT-1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pixel_h <= '0;
      pixel_v <= '0;
      addr <= '0;
      drop_flag <= 1'b0;
    end else begin
      drop_flag <= drop_flag | (pixel_valid & ~accept);
      if (accept) begin
        pixel_h <= (hwrap || last) ? '0 : cur_h + 11'd1;
        pixel_v <= last ? '0 : hwrap ? cur_v + 10'd1 : cur_v;
        addr <= last ? '0 : cur_a + AW'(1);
      end else if (frame_start) begin
        pixel_h <= '0;
        pixel_v <= '0;
        addr <= '0;
      end
    end
  // Per-channel average: one extra bit of headroom, then drop the LSB.
  assign sr = {1'b0, fb_rd_data[4:0]} + {1'b0, p1[4:0]};
  assign sg = {1'b0, fb_rd_data[10:5]} + {1'b0, p1[10:5]};
  assign sb = {1'b0, fb_rd_data[15:11]} + {1'b0, p1[15:11]};
  assign blend = {5'(sb >> 1), 6'(sg >> 1), 5'(sr >> 1)};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v1 <= 1'b0;
      a1 <= '0;
      p1 <= '0;
      ac1 <= 1'b0;
      l1 <= 1'b0;
      fb_wr_en <= 1'b0;
      fb_wr_addr <= '0;
      fb_wr_data <= '0;
      frame_done <= 1'b0;
      frame_count <= '0;
    end else begin
      v1 <= accept;
      a1 <= cur_a;
      p1 <= pixel_in;
      ac1 <= accum_en;
      l1 <= last;
      fb_wr_en <= v1;
      frame_done <= v1 & l1;
      frame_count <= frame_count + 16'(v1 & l1);
      if (v1) begin
        fb_wr_addr <= a1;
        fb_wr_data <= (ac1 && frame_count != 16'd0) ? blend : p1;
      end
    end
endmodule

// File: tb/tb_rtx_fb_writer.sv
// tb_rtx_fb_writer: table-driven check of rtx_fb_writer on a 4x2 frame with a
// behavioural framebuffer memory, plus a hand-written async reset sequence.
module tb_rtx_fb_writer;
  logic clk = 0, rst_n = 0, frame_start = 0, accum_en = 0, pixel_valid = 0, clr = 1;
  logic [15:0] pixel_in = 0, fb_rd_data, fb_wr_data, frame_count;
  logic [2:0] fb_rd_addr, fb_wr_addr;
  logic fb_wr_en, frame_done, drop_flag;
  logic [10:0] pixel_h;
  logic [9:0] pixel_v;
  logic [15:0] mem [8];
  int n_chk = 0, n_fail = 0;

  rtx_fb_writer #(.WIDTH(4), .HEIGHT(2)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .accum_en(accum_en),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .fb_rd_addr(fb_rd_addr),
    .fb_rd_data(fb_rd_data), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
    .fb_wr_en(fb_wr_en), .pixel_h(pixel_h), .pixel_v(pixel_v),
    .frame_done(frame_done), .frame_count(frame_count), .drop_flag(drop_flag));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    fb_rd_data <= mem[fb_rd_addr];
    if (clr) for (int i = 0; i < 8; i++) mem[i] <= '0;
    else if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
  end

  typedef struct {
    logic fs, pv, acc, clr;
    logic [15:0] pix;
    logic [2:0] rd;
    logic wr;
    logic [2:0] wa;
    logic [15:0] wd;
    logic done;
    logic [10:0] h;
    logic [9:0] v;
    logic [15:0] fc;
    logic drop;
  } vec_t;
  vec_t vecs[$];

  int ma = -1, pa = 0, mfc = 0;
  bit pend = 0, pl = 0, mdrop = 0;
  logic [15:0] pd = 0;

  function automatic void add(bit fs, bit pv, bit acc, bit c, logic [15:0] pix, logic [15:0] wd);
    vec_t r;
    bit beat;
    r.fs = fs; r.pv = pv; r.acc = acc; r.clr = c; r.pix = pix;
    r.rd = fs ? 3'd0 : (ma < 0 ? 3'd0 : 3'(ma));
    r.wr = pend; r.wa = 3'(pa); r.wd = pd; r.done = pend && pl;
    if (r.done) mfc++;
    r.fc = 16'(mfc);
    if (fs) ma = 0;
    beat = pv && ma >= 0;
    if (pv && !beat) mdrop = 1;
    r.drop = mdrop;
    pend = beat;
    if (beat) begin
      pa = ma; pd = wd; pl = (ma == 7);
      ma = (ma == 7) ? -1 : ma + 1;
    end
    r.h = ma < 0 ? 11'd0 : 11'(ma % 4);
    r.v = ma < 0 ? 10'd0 : 10'(ma / 4);
    vecs.push_back(r);
  endfunction

  task automatic chk(string n, int i, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %0h want %0h", n, i, act, exp);
    end
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 16'h0, 16'h0);
  endtask

  initial begin
    add(0, 1, 0, 0, 16'h5555, 16'h0);
    idle(2);
    add(1, 0, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 16'h1234, 16'h1234);
    idle(2);
    add(1, 0, 0, 1, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) add(0, 1, 1, 0, 16'hFFFF, 16'h7BEF);
    add(1, 0, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 16'h00AA, 16'h00AA);
    idle(2);
    add(1, 0, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 5; k++) add(0, 1, 0, 0, 16'h0101, 16'h0101);
    add(1, 0, 0, 0, 16'h0, 16'h0);
    for (int k = 0; k < 8; k++) add(0, 1, 0, 0, 16'h0202, 16'h0202);
    idle(2);
    for (int k = 0; k < 8; k++) begin
      add(k == 0, 1, 0, 0, 16'h0303, 16'h0303);
      idle(1);
    end
    idle(2);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_wr_en", -1, 32'(fb_wr_en), 0);
    chk("reset_fc", -1, 32'(frame_count), 0);
    chk("reset_drop", -1, 32'(drop_flag), 0);
    rst_n = 1;
    clr = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      frame_start = vecs[i].fs; pixel_valid = vecs[i].pv;
      accum_en = vecs[i].acc; pixel_in = vecs[i].pix; clr = vecs[i].clr;
      #1 chk("rd_addr", i, 32'(fb_rd_addr), 32'(vecs[i].rd));
      @(posedge clk);
      #1;
      chk("wr_en", i, 32'(fb_wr_en), 32'(vecs[i].wr));
      if (vecs[i].wr) begin
        chk("wr_addr", i, 32'(fb_wr_addr), 32'(vecs[i].wa));
        chk("wr_data", i, 32'(fb_wr_data), 32'(vecs[i].wd));
      end
      chk("frame_done", i, 32'(frame_done), 32'(vecs[i].done));
      chk("pixel_h", i, 32'(pixel_h), 32'(vecs[i].h));
      chk("pixel_v", i, 32'(pixel_v), 32'(vecs[i].v));
      chk("frame_count", i, 32'(frame_count), 32'(vecs[i].fc));
      chk("drop_flag", i, 32'(drop_flag), 32'(vecs[i].drop));
    end

    @(negedge clk);
    frame_start = 1; pixel_valid = 0; clr = 0;
    @(negedge clk);
    frame_start = 0; pixel_valid = 1; pixel_in = 16'h4321;
    @(posedge clk);
    #1 chk("rst_seq_h", 0, 32'(pixel_h), 1);
    @(negedge clk);
    pixel_valid = 0;
    rst_n = 0;
    #1;
    chk("async_wr_en", 0, 32'(fb_wr_en), 0);
    chk("async_wr_addr", 0, 32'(fb_wr_addr), 0);
    chk("async_wr_data", 0, 32'(fb_wr_data), 0);
    chk("async_done", 0, 32'(frame_done), 0);
    chk("async_fc", 0, 32'(frame_count), 0);
    chk("async_drop", 0, 32'(drop_flag), 0);
    chk("async_h", 0, 32'(pixel_h), 0);
    chk("async_v", 0, 32'(pixel_v), 0);
    chk("async_rd_addr", 0, 32'(fb_rd_addr), 0);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 chk("rst_hold_wr_en", i, 32'(fb_wr_en), 0);
    end
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 chk("post_rst_wr_en", i, 32'(fb_wr_en), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
